// File: rtl/full_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// full_subtractor_pkg
//   Shared types and helpers for the one-bit full subtractor.
//   - sub_reg_t   : registered state (difference, borrow, valid)
//   - SUB_REG_RST : reset value of that state
//   - sel_bin()   : effective borrow-in selection (serial vs. external)
// -----------------------------------------------------------------------------
package full_subtractor_pkg;

   typedef struct packed {
      logic s;       // registered difference
      logic borrow;  // borrow register, chained between serial bits
      logic valid;   // in_valid delayed by one cycle
   } sub_reg_t;

   localparam sub_reg_t SUB_REG_RST = '0;

   // In serial mode the borrow comes from the register, except on the first
   // bit of a word where the external borrow seeds the chain.
   function automatic logic sel_bin(input logic ser_en,
                                    input logic ser_start,
                                    input logic borrow_q,
                                    input logic cin);
      return (ser_en & ~ser_start) ? borrow_q : cin;
   endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// -----------------------------------------------------------------------------
// full_sub_cell
//   Purely combinational one-bit full subtractor: a - b - bin = s - 2*bout.
//   Ports:
//     a    in  : minuend bit
//     b    in  : subtrahend bit
//     bin  in  : borrow-in
//     s    out : difference bit
//     bout out : borrow-out
// -----------------------------------------------------------------------------
module full_sub_cell
   import full_subtractor_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic s,
   output logic bout
);

   assign s    = a ^ b ^ bin;
   // Borrow when b exceeds a, or when a == b and a borrow is pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   One-bit full subtractor with combinational and registered outputs plus a
//   bit-serial mode (LSB first, one bit per clock, borrow kept in a flop).
//   Ports:
//     clk       in  : rising-edge clock
//     rst_n     in  : asynchronous active-low reset
//     a         in  : minuend bit
//     b         in  : subtrahend bit
//     cIn       in  : external borrow-in
//     ser_en    in  : serial mode, borrow-in taken from cout_q
//     ser_start in  : first bit of a serial word, borrow-in forced to cIn
//     in_valid  in  : enables update of s_q / cout_q
//     s         out : combinational difference
//     cOut      out : combinational borrow-out
//     s_q       out : registered difference
//     cout_q    out : registered borrow (the serial borrow register)
//     valid_q   out : in_valid delayed one cycle
// -----------------------------------------------------------------------------
module full_subtractor
   import full_subtractor_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic cIn,
   input  logic ser_en,
   input  logic ser_start,
   input  logic in_valid,
   output logic s,
   output logic cOut,
   output logic s_q,
   output logic cout_q,
   output logic valid_q
);

   sub_reg_t reg_q;
   sub_reg_t reg_d;
   logic     bin;

   assign bin = sel_bin(ser_en, ser_start, reg_q.borrow, cIn);

   full_sub_cell u_cell (
      .a    (a),
      .b    (b),
      .bin  (bin),
      .s    (s),
      .bout (cOut)
   );

   // Difference and borrow only advance on valid bits so a stalled serial
   // word keeps its borrow; valid tracks in_valid unconditionally.
   always_comb begin
      reg_d       = reg_q;
      reg_d.valid = in_valid;
      if (in_valid) begin
         reg_d.s      = s;
         reg_d.borrow = cOut;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_q <= SUB_REG_RST;
      end else begin
         reg_q <= reg_d;
      end
   end

   assign s_q     = reg_q.s;
   assign cout_q  = reg_q.borrow;
   assign valid_q = reg_q.valid;

endmodule

// File: tb/tb_full_subtractor.sv
// -----------------------------------------------------------------------------
// tb_full_subtractor
//   Self-checking bench for full_subtractor. Expected registered outputs are
//   pushed to a queue when a bit is driven and popped after the clock edge.
// -----------------------------------------------------------------------------
module tb_full_subtractor;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic a = 1'b0, b = 1'b0, cIn = 1'b0;
   logic ser_en = 1'b0, ser_start = 1'b0, in_valid = 1'b0;
   logic s, cOut, s_q, cout_q, valid_q;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic m_s = 1'b0, m_borrow = 1'b0, m_valid = 1'b0;
   logic [2:0] exp_q [$];

   // per-step observations / expectations
   logic o_s, o_c, e_s, e_c;
   logic [2:0] o_reg, e_reg;

   // truth table indexed by {a,b,cIn} -> {s,cOut}
   logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b01,
                          2'b10, 2'b00, 2'b00, 2'b11};

   always #5 clk = ~clk;

   full_subtractor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .cIn       (cIn),
      .ser_en    (ser_en),
      .ser_start (ser_start),
      .in_valid  (in_valid),
      .s         (s),
      .cOut      (cOut),
      .s_q       (s_q),
      .cout_q    (cout_q),
      .valid_q   (valid_q)
   );

   // Drive one bit, sample combinational outputs mid-cycle, then sample the
   // registered outputs just after the edge and pop the matching expectation.
   task automatic step(input logic ia, input logic ib, input logic icin,
                       input logic ien, input logic istart, input logic ivalid);
      logic bin;
      int   diff;
      @(negedge clk);
      a = ia; b = ib; cIn = icin;
      ser_en = ien; ser_start = istart; in_valid = ivalid;
      bin  = (ien && !istart) ? m_borrow : icin;
      diff = int'(ia) - int'(ib) - int'(bin);
      e_s  = diff[0];
      e_c  = (diff < 0);
      if (ivalid) begin
         m_s      = e_s;
         m_borrow = e_c;
      end
      m_valid = ivalid;
      exp_q.push_back({m_s, m_borrow, m_valid});
      #1;
      o_s = s;
      o_c = cOut;
      @(posedge clk);
      #1;
      o_reg = {s_q, cout_q, valid_q};
      e_reg = exp_q.pop_front();
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({s_q, cout_q, valid_q} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_async got=%b exp=000", {s_q, cout_q, valid_q});
      end
      // inputs active while reset held across an edge: still cleared
      a = 1'b1; b = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({s_q, cout_q, valid_q} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_hold got=%b exp=000", {s_q, cout_q, valid_q});
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      m_s = 1'b0; m_borrow = 1'b0; m_valid = 1'b0;
      $display("reset: outputs=%b", {s_q, cout_q, valid_q});
   endtask

   // All 8 input combinations, once with ser_start=0 and once with
   // ser_start=1 (no effect while ser_en=0).
   task automatic test_comb_sweep();
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 8; i++) begin
            step(i[2], i[1], i[0], 1'b0, p[0], 1'b1);
            n_cmp++;
            if ({o_s, o_c} !== tt[i]) begin
               n_bad++;
               $display("FAIL comb_tt abc=%0d start=%0d got=%b exp=%b", i, p, {o_s, o_c}, tt[i]);
            end
            n_cmp++;
            if (o_reg !== e_reg) begin
               n_bad++;
               $display("FAIL comb_reg abc=%0d got=%b exp=%b", i, o_reg, e_reg);
            end
            $display("comb: abc=%03b start=%0d s/cOut=%b%b regs=%b", i[2:0], p, o_s, o_c, o_reg);
         end
      end
   endtask

   // 5 - 3, with cIn=1 on non-start bits to show it is ignored.
   task automatic test_serial_5_3();
      logic [3:0] wa, wb, word;
      wa = 4'b0101; wb = 4'b0011; word = '0;
      for (int i = 0; i < 4; i++) begin
         step(wa[i], wb[i], (i != 0), 1'b1, (i == 0), 1'b1);
         n_cmp++;
         if ({o_s, o_c} !== {e_s, e_c} || o_reg !== e_reg) begin
            n_bad++;
            $display("FAIL ser53_bit%0d got=%b%b/%b exp=%b%b/%b", i, o_s, o_c, o_reg, e_s, e_c, e_reg);
         end
         word[i] = o_reg[2];
         $display("ser 5-3: bit%0d s_q=%b cout_q=%b", i, o_reg[2], o_reg[1]);
      end
      n_cmp++;
      if ({word, o_reg[1]} !== {4'b0010, 1'b0}) begin
         n_bad++;
         $display("FAIL ser53_word got=%b/%b exp=0010/0", word, o_reg[1]);
      end
   endtask

   // 3 - 5 with a two-cycle in_valid gap after bit 1.
   task automatic test_serial_3_5_stall();
      logic [3:0] wa, wb, word;
      wa = 4'b0011; wb = 4'b0101; word = '0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            for (int g = 0; g < 2; g++) begin
               step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
               n_cmp++;
               if (o_reg !== e_reg) begin
                  n_bad++;
                  $display("FAIL stall_gap%0d got=%b exp=%b", g, o_reg, e_reg);
               end
               $display("ser 3-5: gap%0d regs=%b", g, o_reg);
            end
         end
         step(wa[i], wb[i], 1'b0, 1'b1, (i == 0), 1'b1);
         n_cmp++;
         if ({o_s, o_c} !== {e_s, e_c} || o_reg !== e_reg) begin
            n_bad++;
            $display("FAIL ser35_bit%0d got=%b%b/%b exp=%b%b/%b", i, o_s, o_c, o_reg, e_s, e_c, e_reg);
         end
         word[i] = o_reg[2];
         $display("ser 3-5: bit%0d s_q=%b cout_q=%b", i, o_reg[2], o_reg[1]);
      end
      n_cmp++;
      if ({word, o_reg[1]} !== {4'b1110, 1'b1}) begin
         n_bad++;
         $display("FAIL ser35_word got=%b/%b exp=1110/1", word, o_reg[1]);
      end
   endtask

   // Reset between edges after bit 1 of 3 - 5, then a fresh 5 - 3 word.
   task automatic test_reset_mid_word();
      logic [3:0] wa, wb, word;
      wa = 4'b0011; wb = 4'b0101;
      for (int i = 0; i < 2; i++) begin
         step(wa[i], wb[i], 1'b0, 1'b1, (i == 0), 1'b1);
      end
      n_cmp++;
      if (o_reg !== e_reg) begin
         n_bad++;
         $display("FAIL midrst_pre got=%b exp=%b", o_reg, e_reg);
      end
      #2 rst_n = 1'b0;
      #1;
      m_s = 1'b0; m_borrow = 1'b0; m_valid = 1'b0;
      n_cmp++;
      if ({s_q, cout_q, valid_q} !== 3'b000) begin
         n_bad++;
         $display("FAIL midrst_clear got=%b exp=000", {s_q, cout_q, valid_q});
      end
      $display("mid-word reset: regs=%b", {s_q, cout_q, valid_q});
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      wa = 4'b0101; wb = 4'b0011; word = '0;
      for (int i = 0; i < 4; i++) begin
         step(wa[i], wb[i], 1'b0, 1'b1, (i == 0), 1'b1);
         n_cmp++;
         if (o_reg !== e_reg) begin
            n_bad++;
            $display("FAIL midrst_bit%0d got=%b exp=%b", i, o_reg, e_reg);
         end
         word[i] = o_reg[2];
      end
      n_cmp++;
      if ({word, o_reg[1]} !== {4'b0010, 1'b0}) begin
         n_bad++;
         $display("FAIL midrst_word got=%b/%b exp=0010/0", word, o_reg[1]);
      end
      $display("after reset 5-3: word=%b borrow=%b", word, o_reg[1]);
   endtask

   // 0 - 0 seeded with cIn=1 on the start bit.
   task automatic test_start_cin();
      logic [3:0] word;
      word = '0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, (i == 0), 1'b1, (i == 0), 1'b1);
         n_cmp++;
         if ({o_s, o_c} !== {e_s, e_c} || o_reg !== e_reg) begin
            n_bad++;
            $display("FAIL cin_bit%0d got=%b%b/%b exp=%b%b/%b", i, o_s, o_c, o_reg, e_s, e_c, e_reg);
         end
         word[i] = o_reg[2];
      end
      n_cmp++;
      if ({word, o_reg[1]} !== {4'b1111, 1'b1}) begin
         n_bad++;
         $display("FAIL cin_word got=%b/%b exp=1111/1", word, o_reg[1]);
      end
      $display("0-0 cIn=1: word=%b borrow=%b", word, o_reg[1]);
   endtask

   task automatic test_back_to_back();
      // idle cycle drops valid_q; scoreboard must be drained
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (o_reg !== e_reg) begin
         n_bad++;
         $display("FAIL idle_hold got=%b exp=%b", o_reg, e_reg);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain got=%0d exp=0", exp_q.size());
      end
      $display("idle: regs=%b", o_reg);
   endtask

   initial begin
      test_reset();
      test_comb_sweep();
      test_serial_5_3();
      test_serial_3_5_stall();
      test_reset_mid_word();
      test_start_cin();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
